// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: per-producer FIFOs (ALU, load/store) merged onto one registered
// register-file write port. MEM has priority; a starvation counter forces an ALU win.
module reg_wb_arbiter #(
   parameter int REG_DATA_WIDTH_POW = 6,
   parameter int REG_MEM_DEPTH_POW  = 5,
   parameter int FIFO_DEPTH_POW     = 2,
   parameter int STARVE_LIMIT       = 4
) (
   input  logic                               clk_in,
   input  logic                               rst_n_in,
   input  logic                               alu_valid_in,
   input  logic [REG_MEM_DEPTH_POW-1:0]       alu_rd_in,
   input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] alu_data_in,
   output logic                               alu_ready_out,
   input  logic                               mem_valid_in,
   input  logic [REG_MEM_DEPTH_POW-1:0]       mem_rd_in,
   input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] mem_data_in,
   output logic                               mem_ready_out,
   output logic [REG_MEM_DEPTH_POW-1:0]       rd_out,
   output logic [(1<<REG_DATA_WIDTH_POW)-1:0] data_write_out,
   output logic                               write_en_out,
   output logic [FIFO_DEPTH_POW:0]            alu_count_out,
   output logic [FIFO_DEPTH_POW:0]            mem_count_out
);
   localparam int DW    = 1 << REG_DATA_WIDTH_POW;
   localparam int RW    = REG_MEM_DEPTH_POW;
   localparam int PW    = FIFO_DEPTH_POW;
   localparam int DEPTH = 1 << PW;
   localparam int ALU   = 0;
   localparam int MEM   = 1;
   localparam logic [PW:0] FULL_CNT   = (PW+1)'(DEPTH);
   localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

   logic [RW-1:0] fifo_rd   [2][DEPTH];
   logic [DW-1:0] fifo_data [2][DEPTH];
   logic [PW-1:0] wr_ptr    [2];
   logic [PW-1:0] rd_ptr    [2];
   logic [PW:0]   count     [2];
   logic [3:0]    starve_cnt;

   logic [RW-1:0] in_rd   [2];
   logic [DW-1:0] in_data [2];
   logic [1:0]    in_vld;
   logic [1:0]    ready;
   logic [1:0]    head_vld;
   logic [1:0]    push;
   logic [1:0]    pop;
   logic          grant_alu;
   logic          grant_mem;
   logic [RW-1:0] win_rd;
   logic [DW-1:0] win_data;

   assign in_vld         = {mem_valid_in, alu_valid_in};
   assign in_rd[ALU]     = alu_rd_in;
   assign in_rd[MEM]     = mem_rd_in;
   assign in_data[ALU]   = alu_data_in;
   assign in_data[MEM]   = mem_data_in;

   // Readiness comes only from registered occupancy, never from valid.
   assign ready    = {count[MEM] != FULL_CNT, count[ALU] != FULL_CNT};
   assign head_vld = {count[MEM] != '0, count[ALU] != '0};
   // x0 results complete the handshake but are never stored.
   assign push     = in_vld & ready & {in_rd[MEM] != '0, in_rd[ALU] != '0};

   assign grant_alu = head_vld[ALU] && (!head_vld[MEM] || starve_cnt == STARVE_MAX);
   assign grant_mem = head_vld[MEM] && !grant_alu;
   assign pop       = {grant_mem, grant_alu};
   assign win_rd    = grant_alu ? fifo_rd[ALU][rd_ptr[ALU]]   : fifo_rd[MEM][rd_ptr[MEM]];
   assign win_data  = grant_alu ? fifo_data[ALU][rd_ptr[ALU]] : fifo_data[MEM][rd_ptr[MEM]];

   assign alu_ready_out = ready[ALU];
   assign mem_ready_out = ready[MEM];
   assign alu_count_out = count[ALU];
   assign mem_count_out = count[MEM];

   always_ff @(posedge clk_in) begin
      for (int c = 0; c < 2; c++) begin
         if (push[c]) begin
            fifo_rd[c][wr_ptr[c]]   <= in_rd[c];
            fifo_data[c][wr_ptr[c]] <= in_data[c];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int c = 0; c < 2; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            count[c]  <= '0;
         end
         starve_cnt <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
            if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
            if (push[c] && !pop[c])
               count[c] <= count[c] + 1'b1;
            else if (!push[c] && pop[c])
               count[c] <= count[c] - 1'b1;
         end
         if (grant_alu)
            starve_cnt <= '0;
         else if (grant_mem && head_vld[ALU] && starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Output stage: rd/data hold their last value on idle cycles.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         write_en_out   <= 1'b0;
         rd_out         <= '0;
         data_write_out <= '0;
      end else begin
         write_en_out <= grant_alu || grant_mem;
         if (grant_alu || grant_mem) begin
            rd_out         <= win_rd;
            data_write_out <= win_data;
         end
      end
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: per-channel expected-write queues checked by a write monitor,
// plus per-scenario timing checks.
module tb_reg_wb_arbiter;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } exp_t;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        alu_valid_in = 1'b0;
   logic [4:0]  alu_rd_in = '0;
   logic [63:0] alu_data_in = '0;
   logic        alu_ready_out;
   logic        mem_valid_in = 1'b0;
   logic [4:0]  mem_rd_in = '0;
   logic [63:0] mem_data_in = '0;
   logic        mem_ready_out;
   logic [4:0]  rd_out;
   logic [63:0] data_write_out;
   logic        write_en_out;
   logic [2:0]  alu_count_out;
   logic [2:0]  mem_count_out;

   int   tests_run = 0;
   int   failed = 0;
   int   wr_count = 0;
   int   wr_log[$];
   exp_t exp_alu[$];
   exp_t exp_mem[$];

   reg_wb_arbiter dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .alu_valid_in   (alu_valid_in),
      .alu_rd_in      (alu_rd_in),
      .alu_data_in    (alu_data_in),
      .alu_ready_out  (alu_ready_out),
      .mem_valid_in   (mem_valid_in),
      .mem_rd_in      (mem_rd_in),
      .mem_data_in    (mem_data_in),
      .mem_ready_out  (mem_ready_out),
      .rd_out         (rd_out),
      .data_write_out (data_write_out),
      .write_en_out   (write_en_out),
      .alu_count_out  (alu_count_out),
      .mem_count_out  (mem_count_out)
   );

   always #5 clk_in = ~clk_in;

   // Every write must match the head of one channel's expected queue.
   always @(negedge clk_in) begin
      if (rst_n_in && write_en_out === 1'b1) begin
         tests_run++;
         wr_count++;
         if (exp_mem.size() > 0 && exp_mem[0].rd == rd_out) begin
            wr_log.push_back(1);
            if (data_write_out !== exp_mem[0].data) begin
               failed++;
               $display("FAIL wb_data_mem rd=%0d got %h expected %h", rd_out, data_write_out, exp_mem[0].data);
            end
            void'(exp_mem.pop_front());
         end else if (exp_alu.size() > 0 && exp_alu[0].rd == rd_out) begin
            wr_log.push_back(0);
            if (data_write_out !== exp_alu[0].data) begin
               failed++;
               $display("FAIL wb_data_alu rd=%0d got %h expected %h", rd_out, data_write_out, exp_alu[0].data);
            end
            void'(exp_alu.pop_front());
         end else begin
            failed++;
            $display("FAIL wb_unexpected got rd=%0d data=%h, expected no write or a queue head", rd_out, data_write_out);
         end
      end
   end

   task automatic send(input int ch, input logic [4:0] rd, input logic [63:0] data);
      int n = 0;
      exp_t e;
      e.rd = rd;
      e.data = data;
      if (ch == 0) begin
         alu_valid_in = 1'b1; alu_rd_in = rd; alu_data_in = data;
      end else begin
         mem_valid_in = 1'b1; mem_rd_in = rd; mem_data_in = data;
      end
      while (((ch == 0) ? alu_ready_out : mem_ready_out) !== 1'b1 && n < 100) begin
         @(negedge clk_in);
         n++;
      end
      if (n >= 100) begin
         tests_run++;
         failed++;
         $display("FAIL send_timeout ch=%0d ready stayed 0, expected 1 within 100 cycles", ch);
      end else if (rd != 5'd0) begin
         if (ch == 0) exp_alu.push_back(e);
         else         exp_mem.push_back(e);
      end
      @(negedge clk_in);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_alu.size() != 0 || exp_mem.size() != 0) && n < 80) begin
         @(negedge clk_in);
         n++;
      end
      tests_run++;
      if (exp_alu.size() != 0 || exp_mem.size() != 0) begin
         failed++;
         $display("FAIL drain pending alu=%0d mem=%0d expected 0 0", exp_alu.size(), exp_mem.size());
      end
      repeat (2) @(negedge clk_in);
   endtask

   task automatic test_reset();
      #3;
      tests_run++;
      if (write_en_out !== 1'b0) begin failed++; $display("FAIL reset_we got %b expected 0", write_en_out); end
      tests_run++;
      if (rd_out !== 5'd0) begin failed++; $display("FAIL reset_rd got %0d expected 0", rd_out); end
      tests_run++;
      if (data_write_out !== 64'd0) begin failed++; $display("FAIL reset_data got %h expected 0", data_write_out); end
      tests_run++;
      if (alu_ready_out !== 1'b1 || mem_ready_out !== 1'b1) begin
         failed++; $display("FAIL reset_ready got %b%b expected 11", alu_ready_out, mem_ready_out);
      end
      tests_run++;
      if (alu_count_out !== 3'd0 || mem_count_out !== 3'd0) begin
         failed++; $display("FAIL reset_count got %0d/%0d expected 0/0", alu_count_out, mem_count_out);
      end
      @(negedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);
   endtask

   task automatic test_single_alu();
      exp_t e;
      e.rd = 5'd5;
      e.data = 64'hDEAD_BEEF;
      alu_valid_in = 1'b1; alu_rd_in = 5'd5; alu_data_in = 64'hDEAD_BEEF;
      exp_alu.push_back(e);
      @(negedge clk_in);
      alu_valid_in = 1'b0;
      tests_run++;
      if (alu_count_out !== 3'd1 || write_en_out !== 1'b0) begin
         failed++; $display("FAIL single_edge1 got count=%0d we=%b expected 1 0", alu_count_out, write_en_out);
      end
      @(negedge clk_in);
      tests_run++;
      if (write_en_out !== 1'b1 || rd_out !== 5'd5 || data_write_out !== 64'hDEAD_BEEF) begin
         failed++;
         $display("FAIL single_edge2 got we=%b rd=%0d data=%h expected 1 5 deadbeef", write_en_out, rd_out, data_write_out);
      end
      tests_run++;
      if (alu_count_out !== 3'd0) begin failed++; $display("FAIL single_count got %0d expected 0", alu_count_out); end
      @(negedge clk_in);
      tests_run++;
      if (write_en_out !== 1'b0 || rd_out !== 5'd5) begin
         failed++; $display("FAIL single_idle got we=%b rd=%0d expected 0 5", write_en_out, rd_out);
      end
      wait_drain();
   endtask

   task automatic test_x0();
      tests_run++;
      if (alu_ready_out !== 1'b1) begin failed++; $display("FAIL x0_ready got %b expected 1", alu_ready_out); end
      alu_valid_in = 1'b1; alu_rd_in = 5'd0; alu_data_in = 64'h1234;
      @(negedge clk_in);
      alu_valid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (alu_count_out !== 3'd0 || write_en_out !== 1'b0) begin
            failed++; $display("FAIL x0_drop got count=%0d we=%b expected 0 0", alu_count_out, write_en_out);
         end
         @(negedge clk_in);
      end
   endtask

   task automatic test_fill_backpressure();
      exp_t e;
      for (int i = 1; i <= 5; i++) begin
         tests_run++;
         if (mem_ready_out !== 1'b1) begin failed++; $display("FAIL fill_ready i=%0d got %b expected 1", i, mem_ready_out); end
         tests_run++;
         if (mem_count_out !== ((i == 1) ? 3'd0 : 3'd1)) begin
            failed++; $display("FAIL fill_count i=%0d got %0d expected %0d", i, mem_count_out, (i == 1) ? 0 : 1);
         end
         if (i >= 3) begin
            tests_run++;
            if (write_en_out !== 1'b1 || rd_out !== 5'(i - 2)) begin
               failed++; $display("FAIL fill_order got we=%b rd=%0d expected 1 %0d", write_en_out, rd_out, i - 2);
            end
         end
         e.rd = 5'(i);
         e.data = 64'hA000 + 64'(i);
         mem_valid_in = 1'b1; mem_rd_in = e.rd; mem_data_in = e.data;
         exp_mem.push_back(e);
         @(negedge clk_in);
      end
      mem_valid_in = 1'b0;
      for (int k = 4; k <= 5; k++) begin
         tests_run++;
         if (write_en_out !== 1'b1 || rd_out !== 5'(k)) begin
            failed++; $display("FAIL fill_tail got we=%b rd=%0d expected 1 %0d", write_en_out, rd_out, k);
         end
         @(negedge clk_in);
      end
      tests_run++;
      if (write_en_out !== 1'b0) begin failed++; $display("FAIL fill_end got we=%b expected 0", write_en_out); end
      wait_drain();
   endtask

   task automatic test_starvation();
      wr_log.delete();
      fork
         begin
            for (int i = 0; i < 8; i++) send(0, 5'(10 + i), 64'hA1_0000 + 64'(i));
            alu_valid_in = 1'b0;
         end
         begin
            for (int i = 0; i < 12; i++) send(1, 5'(20 + i), 64'hB2_0000 + 64'(i));
            mem_valid_in = 1'b0;
         end
         begin
            repeat (5) @(negedge clk_in);
            tests_run++;
            if (alu_count_out !== 3'd4 || alu_ready_out !== 1'b0) begin
               failed++; $display("FAIL starve_full got count=%0d ready=%b expected 4 0", alu_count_out, alu_ready_out);
            end
         end
      join
      wait_drain();
      tests_run++;
      if (wr_log.size() < 15) begin
         failed++; $display("FAIL starve_len got %0d writes expected >= 15", wr_log.size());
      end else begin
         for (int k = 0; k < 15; k++) begin
            tests_run++;
            if (wr_log[k] != (((k % 5) == 4) ? 0 : 1)) begin
               failed++; $display("FAIL starve_pattern idx=%0d got ch=%0d expected ch=%0d (0=alu 1=mem)", k, wr_log[k], ((k % 5) == 4) ? 0 : 1);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      e.rd = 5'd6; e.data = 64'h66;
      exp_alu.push_back(e);
      alu_valid_in = 1'b1; alu_rd_in = 5'd6; alu_data_in = 64'h66;
      e.rd = 5'd7; e.data = 64'h77;
      exp_mem.push_back(e);
      mem_valid_in = 1'b1; mem_rd_in = 5'd7; mem_data_in = 64'h77;
      @(negedge clk_in);
      mem_valid_in = 1'b0;
      e.rd = 5'd8; e.data = 64'h88;
      exp_alu.push_back(e);
      alu_rd_in = 5'd8; alu_data_in = 64'h88;
      @(negedge clk_in);
      tests_run++;
      if (alu_count_out !== 3'd2 || rd_out !== 5'd7) begin
         failed++; $display("FAIL b2b_setup got count=%0d rd=%0d expected 2 7", alu_count_out, rd_out);
      end
      e.rd = 5'd9; e.data = 64'h99;
      exp_alu.push_back(e);
      alu_rd_in = 5'd9; alu_data_in = 64'h99;
      @(negedge clk_in);
      alu_valid_in = 1'b0;
      tests_run++;
      if (alu_count_out !== 3'd2 || write_en_out !== 1'b1 || rd_out !== 5'd6) begin
         failed++; $display("FAIL b2b_simul got count=%0d we=%b rd=%0d expected 2 1 6", alu_count_out, write_en_out, rd_out);
      end
      @(negedge clk_in);
      tests_run++;
      if (rd_out !== 5'd8) begin failed++; $display("FAIL b2b_order2 got rd=%0d expected 8", rd_out); end
      @(negedge clk_in);
      tests_run++;
      if (rd_out !== 5'd9) begin failed++; $display("FAIL b2b_order3 got rd=%0d expected 9", rd_out); end
      wait_drain();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int wr_before;
      for (int i = 0; i < 3; i++) begin
         e.rd = 5'(11 + i); e.data = 64'hC0 + 64'(i);
         exp_alu.push_back(e);
         alu_valid_in = 1'b1; alu_rd_in = e.rd; alu_data_in = e.data;
         e.rd = 5'(21 + i); e.data = 64'hD0 + 64'(i);
         exp_mem.push_back(e);
         mem_valid_in = 1'b1; mem_rd_in = e.rd; mem_data_in = e.data;
         @(negedge clk_in);
      end
      alu_valid_in = 1'b0;
      mem_valid_in = 1'b0;
      tests_run++;
      if (alu_count_out !== 3'd3 || mem_count_out !== 3'd1 || write_en_out !== 1'b1) begin
         failed++; $display("FAIL rstmid_pre got alu=%0d mem=%0d we=%b expected 3 1 1", alu_count_out, mem_count_out, write_en_out);
      end
      #2;
      rst_n_in = 1'b0;
      exp_alu.delete();
      exp_mem.delete();
      #1;
      tests_run++;
      if (write_en_out !== 1'b0 || rd_out !== 5'd0 || data_write_out !== 64'd0) begin
         failed++; $display("FAIL rstmid_out got we=%b rd=%0d data=%h expected 0 0 0", write_en_out, rd_out, data_write_out);
      end
      tests_run++;
      if (alu_count_out !== 3'd0 || mem_count_out !== 3'd0 || alu_ready_out !== 1'b1 || mem_ready_out !== 1'b1) begin
         failed++;
         $display("FAIL rstmid_fifo got counts=%0d/%0d ready=%b%b expected 0/0 11", alu_count_out, mem_count_out, alu_ready_out, mem_ready_out);
      end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      wr_before = wr_count;
      repeat (10) @(negedge clk_in);
      tests_run++;
      if (wr_count != wr_before) begin
         failed++; $display("FAIL rstmid_stale got %0d writes after reset expected 0", wr_count - wr_before);
      end
   endtask

   initial begin
      @(negedge clk_in);
      test_reset();
      test_single_alu();
      test_x0();
      test_fill_backpressure();
      test_starvation();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
